// File: rtl/grng_pkg.sv
// grng_pkg: shared Q-format constants, default widths and the stage payload layout.
package grng_pkg;
   localparam int COORD_FRAC = 14;
   localparam int RATIO_FRAC = 28;
   localparam int RAND_FRAC = 28;
   localparam int DEF_LOG2N = 8;
   localparam int DEF_COORD_W = 18;
   localparam int DEF_RATIO_W = 32;
   localparam int DEF_RAND_W = 32;
   // Field order matches the packed payload vector carried by each pipeline stage.
   typedef struct packed {
      logic signed [2*DEF_COORD_W-1:0] mult;
      logic cmp;
      logic [DEF_LOG2N-1:0] rect_idx;
      logic signed [DEF_RAND_W-1:0] rand1;
      logic signed [DEF_RAND_W-1:0] rand2;
   } stage_payload_t;
endpackage

// File: rtl/stage3_pipe_reg.sv
// stage3_pipe_reg: one stall-able pipeline register holding a valid bit and its payload.
module stage3_pipe_reg #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         d_valid,
   input  logic [W-1:0] d,
   output logic         q_valid,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q_valid <= 1'b0;
         q <= '0;
      end else begin
         if (clr) q_valid <= 1'b0;
         else if (en) q_valid <= d_valid;
         if (en) q <= d;
      end
endmodule

// File: rtl/stage3_pipe.sv
// stage3_pipe: LAT-deep elastic pipeline computing a signed product and an unsigned compare with aligned sidebands.
module stage3_pipe
   import grng_pkg::*;
#(
   parameter int LOG2N = DEF_LOG2N,
   parameter int COORD_W = DEF_COORD_W,
   parameter int RATIO_W = DEF_RATIO_W,
   parameter int RAND_W = DEF_RAND_W,
   parameter int LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      valid_in,
   output logic                      ready_out,
   input  logic signed [COORD_W-1:0] rmost_coord,
   input  logic signed [COORD_W-1:0] trunc_value,
   input  logic [RATIO_W-1:0]        abs_value,
   input  logic [RATIO_W-1:0]        wedge_bound_ratio,
   input  logic [LOG2N-1:0]          rect_idx_in,
   input  logic signed [RAND_W-1:0]  rand1_in,
   input  logic signed [RAND_W-1:0]  rand2_in,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic signed [2*COORD_W-1:0] mult_value,
   output logic                      cmp_value,
   output logic [LOG2N-1:0]          rect_idx_out,
   output logic signed [RAND_W-1:0]  rand1_out,
   output logic signed [RAND_W-1:0]  rand2_out,
   output logic [31:0]               hit_count
);
   localparam int PW = 2*COORD_W + 1 + LOG2N + 2*RAND_W;
   logic advance;
   logic signed [2*COORD_W-1:0] prod;
   logic [PW-1:0] din;
   logic vq [LAT];
   logic [PW-1:0] dq [LAT];
   assign advance = !valid_out || ready_in;
   assign ready_out = advance && !flush;
   // Operands are sign-extended first so the truncated product is the exact full-width result.
   assign prod = (2*COORD_W)'(rmost_coord) * (2*COORD_W)'(trunc_value);
   assign din = {prod, abs_value < wedge_bound_ratio, rect_idx_in, rand1_in, rand2_in};
   for (genvar i = 0; i < LAT; i++) begin : g_stage
      stage3_pipe_reg #(.W(PW)) u_reg (
         .clk(clk),
         .rst(rst),
         .en(advance),
         .clr(flush),
         .d_valid(i == 0 ? valid_in : vq[i == 0 ? 0 : i-1]),
         .d(i == 0 ? din : dq[i == 0 ? 0 : i-1]),
         .q_valid(vq[i]),
         .q(dq[i])
      );
   end
   assign valid_out = vq[LAT-1];
   assign {mult_value, cmp_value, rect_idx_out, rand1_out, rand2_out} = dq[LAT-1];
   always_ff @(posedge clk or posedge rst)
      if (rst) hit_count <= '0;
      else if (valid_out && ready_in && cmp_value) hit_count <= hit_count + 32'd1;
endmodule

// File: tb/tb_stage3_pipe.sv
// tb_stage3_pipe: randomized and directed checks of stage3_pipe against an in-order scoreboard model.
module tb_stage3_pipe;
   import grng_pkg::*;
   localparam int LAT = 3;
   logic clk = 0, rst = 1, flush = 0, valid_in = 0, ready_in = 0;
   logic signed [17:0] rmost_coord = 0, trunc_value = 0;
   logic [31:0] abs_value = 0, wedge_bound_ratio = 0;
   logic [7:0] rect_idx_in = 0;
   logic signed [31:0] rand1_in = 0, rand2_in = 0;
   logic ready_out, valid_out, cmp_value;
   logic signed [35:0] mult_value;
   logic [7:0] rect_idx_out;
   logic signed [31:0] rand1_out, rand2_out;
   logic [31:0] hit_count;
   int n_chk = 0, n_fail = 0;
   stage_payload_t exp_q[$];
   logic [31:0] hits = 0;
   bit held = 0, seen_vo = 0, acc = 0;
   stage_payload_t held_val, seen_obs;

   stage3_pipe #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
      .rmost_coord(rmost_coord), .trunc_value(trunc_value), .abs_value(abs_value),
      .wedge_bound_ratio(wedge_bound_ratio), .rect_idx_in(rect_idx_in), .rand1_in(rand1_in),
      .rand2_in(rand2_in), .valid_out(valid_out), .ready_in(ready_in), .mult_value(mult_value),
      .cmp_value(cmp_value), .rect_idx_out(rect_idx_out), .rand1_out(rand1_out),
      .rand2_out(rand2_out), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic stage_payload_t model_beat();
      stage_payload_t b;
      b.mult = 36'(longint'(rmost_coord) * longint'(trunc_value));
      b.cmp = abs_value < wedge_bound_ratio;
      b.rect_idx = rect_idx_in;
      b.rand1 = rand1_in;
      b.rand2 = rand2_in;
      return b;
   endfunction

   task automatic rand_data();
      rmost_coord = 18'($urandom);
      trunc_value = 18'($urandom);
      abs_value = $urandom;
      wedge_bound_ratio = ($urandom_range(0, 3) == 0) ? abs_value : $urandom;
      rect_idx_in = 8'($urandom);
      rand1_in = $urandom;
      rand2_in = $urandom;
   endtask

   task automatic cyc(input bit vi, input bit ri, input bit fl);
      stage_payload_t obs, e;
      valid_in = vi;
      ready_in = ri;
      flush = fl;
      #1;
      obs = {mult_value, cmp_value, rect_idx_out, rand1_out, rand2_out};
      seen_vo = valid_out;
      seen_obs = obs;
      chk("ready_out", 128'(ready_out), 128'((!valid_out || ri) && !fl));
      if (held) begin
         chk("hold_valid", 128'(valid_out), 128'(1));
         chk("hold_data", 128'(obs), 128'(held_val));
      end
      if (valid_out) chk("valid_has_beat", 128'(exp_q.size() != 0), 128'(1));
      if (valid_out && ri && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("beat", 128'(obs), 128'(e));
         if (e.cmp) hits++;
      end
      acc = vi && (!valid_out || ri) && !fl;
      if (acc) exp_q.push_back(model_beat());
      if (fl) exp_q.delete();
      held = valid_out && !ri && !fl;
      held_val = obs;
      @(posedge clk);
      @(negedge clk);
      chk("hit_count", 128'(hit_count), 128'(hits));
   endtask

   task automatic drain();
      repeat (LAT + 2) cyc(0, 1, 0);
   endtask

   task automatic latency(input string tag);
      int lat = 0;
      logic [35:0] mval = '0;
      cyc(1, 1, 0);
      for (int k = 1; k <= LAT + 3; k++) begin
         cyc(0, 1, 0);
         if (seen_vo && lat == 0) begin
            lat = k;
            mval = seen_obs.mult;
         end
      end
      chk(tag, 128'(lat), 128'(LAT));
      if (tag == "latency_041") chk("mult_041", 128'(mval), 128'(36'hFC8000000));
   endtask

   initial begin
      logic [3:0] pat = 4'b1001;
      logic [4:0] cmp_pat = 5'b01101;
      logic c0, c1;
      int sent, nidx, ncmp;
      #1;
      chk("rst_valid", 128'(valid_out), 128'(0));
      chk("rst_hits", 128'(hit_count), 128'(0));
      chk("rst_data", 128'({mult_value, cmp_value, rect_idx_out, rand1_out, rand2_out}), 128'(0));
      @(negedge clk);
      rst = 0;
      #1;
      chk("ready_after_reset", 128'(ready_out), 128'(1));
      rand_data();
      rmost_coord = 18'sh0E000;
      trunc_value = 18'sh3C000;
      latency("latency_041");
      // equal operands must not compare as less-than; one LSB larger must
      rand_data();
      abs_value = 32'h10000000;
      wedge_bound_ratio = 32'h10000000;
      cyc(1, 1, 0);
      wedge_bound_ratio = 32'h10000001;
      cyc(1, 1, 0);
      ncmp = 0;
      c0 = 1'b1;
      c1 = 1'b0;
      for (int k = 0; k < LAT + 2; k++) begin
         cyc(0, 1, 0);
         if (seen_vo) begin
            if (ncmp == 0) c0 = seen_obs.cmp;
            else c1 = seen_obs.cmp;
            ncmp++;
         end
      end
      chk("cmp_equal", 128'(c0), 128'(0));
      chk("cmp_less", 128'(c1), 128'(1));
      sent = 0;
      nidx = 0;
      for (int cy = 0; cy < 60 && (sent < 8 || exp_q.size() != 0); cy++) begin
         rand_data();
         rect_idx_in = 8'(sent);
         cyc(sent < 8, pat[cy % 4], 0);
         if (seen_vo && ready_in) begin
            chk("idx_order", 128'(seen_obs.rect_idx), 128'(nidx));
            nidx++;
         end
         if (acc) sent++;
      end
      chk("order_count", 128'(nidx), 128'(8));
      repeat (3) begin
         rand_data();
         cyc(1, 0, 0);
      end
      cyc(0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, 0);
         chk("flush_quiet", 128'(seen_vo), 128'(0));
      end
      rand_data();
      latency("latency_after_flush");
      for (int k = 0; k < 400; k++) begin
         rand_data();
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      end
      for (int k = 0; k < 3; k++) begin
         rand_data();
         cyc(1, 0, 0);
      end
      #2;
      rst = 1;
      #1;
      chk("async_rst_valid", 128'(valid_out), 128'(0));
      chk("async_rst_hits", 128'(hit_count), 128'(0));
      chk("async_rst_data", 128'({mult_value, cmp_value, rect_idx_out, rand1_out, rand2_out}), 128'(0));
      exp_q.delete();
      hits = 0;
      held = 0;
      valid_in = 0;
      ready_in = 0;
      flush = 0;
      @(negedge clk);
      rst = 0;
      #1;
      chk("ready_after_release", 128'(ready_out), 128'(1));
      for (int k = 0; k < 5; k++) begin
         rand_data();
         abs_value = 32'd1;
         wedge_bound_ratio = cmp_pat[k] ? 32'd2 : 32'd1;
         cyc(1, 1, 0);
      end
      drain();
      repeat (2) begin
         rand_data();
         abs_value = 32'd1;
         wedge_bound_ratio = 32'd2;
         cyc(1, 0, 0);
      end
      cyc(0, 0, 1);
      drain();
      chk("hits_046", 128'(hit_count), 128'(3));
      chk("drained", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stage3_pipe.md
STAGE3_PIPE -- requirements
Module: stage3_pipe

Interface
REQ-001 Parameter LOG2N, default 8: width of the rectangle index.
REQ-002 Parameter COORD_W, default 18: width of the signed Q3.14 coordinate operands.
REQ-003 Parameter RATIO_W, default 32: width of the unsigned UQ4.28 compare operands.
REQ-004 Parameter RAND_W, default 32: width of the signed Q3.28 random sidebands.
REQ-005 Parameter LAT, default 2, legal 1..4: pipeline depth in cycles.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 flush  in  1  synchronous pipeline clear.
REQ-009 valid_in  in  1  an input beat is present.
REQ-010 ready_out  out  1  stage can accept a beat this cycle.
REQ-011 rmost_coord, trunc_value  in  COORD_W each  signed Q3.14 multiply operands.
REQ-012 abs_value, wedge_bound_ratio  in  RATIO_W each  unsigned UQ4.28 compare operands.
REQ-013 rect_idx_in  in  LOG2N  rectangle index sideband.
REQ-014 rand1_in, rand2_in  in  RAND_W each  signed sidebands.
REQ-015 valid_out  out  1  an output beat is present.
REQ-016 ready_in  in  1  downstream accepts the beat this cycle.
REQ-017 mult_value  out  2*COORD_W  signed product, Q7.28 at default widths.
REQ-018 cmp_value  out  1  compare result.
REQ-019 rect_idx_out  out  LOG2N  aligned rectangle index.
REQ-020 rand1_out, rand2_out  out  RAND_W each  aligned sidebands.
REQ-021 hit_count  out  32  count of delivered beats with cmp_value=1.

Function
REQ-022 Each beat SHALL compute mult_value = rmost_coord * trunc_value as a full-width signed product, with no truncation or rounding.
REQ-023 cmp_value SHALL be 1 iff abs_value < wedge_bound_ratio (unsigned), and 0 when the two are equal.
REQ-024 All result and sideband fields of one beat SHALL emerge together, exactly LAT cycles after acceptance when there is no stall; sidebands are registered, not passed through.
REQ-025 A beat SHALL be accepted iff valid_in && ready_out.
REQ-026 A beat SHALL be delivered iff valid_out && ready_in.
REQ-027 advance = !valid_out || ready_in; ready_out SHALL equal advance && !flush.
REQ-028 When advance=0, every pipeline stage SHALL hold its contents, and output data SHALL remain stable while valid_out=1.
REQ-029 When advance=1, each stage SHALL shift forward by one; stage 0 loads the input beat with valid = valid_in && !flush.
REQ-030 Bubbles (stage valid=0) SHALL shift through the pipeline and never produce valid_out.
REQ-031 Beats SHALL be delivered in acceptance order, with none lost or duplicated.
REQ-032 flush=1 SHALL clear all stage valids at the next edge; ready_out=0 during flush; data registers need not clear.
REQ-033 When flush and a delivery occur in the same cycle, the delivery SHALL complete and the beat SHALL be counted.
REQ-034 hit_count SHALL increment by 1 per delivered beat with cmp_value=1, wrap from 0xFFFFFFFF to 0, and be unaffected by flush.
REQ-035 The 2*COORD_W multiply SHALL be registered inside the pipeline, not as a combinational path from inputs to outputs.

Reset
REQ-036 rst=1 SHALL asynchronously clear all stage valids, valid_out and hit_count to 0.
REQ-037 On rst=1, mult_value, cmp_value, rect_idx_out, rand1_out and rand2_out SHALL clear to 0.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight beats; ready_out=1 in the first cycle after release.

Structure
REQ-039 The Q-format constants (COORD_FRAC=14, RATIO_FRAC=28, RAND_FRAC=28) and the stage payload struct type SHALL live in the shared package grng_pkg.
REQ-040 One sub-module, stage3_pipe_reg, SHALL implement one stall-able pipeline register (valid + payload) and be instantiated LAT times.

Verification
REQ-041 Scenario: rmost_coord=0x0E000 (3.5), trunc_value=0x3C000 (-1.0), ready_in=1 -> mult_value=0xFC8000000 exactly LAT cycles later.
REQ-042 Scenario: abs_value=0x10000000, wedge_bound_ratio=0x10000000 -> cmp_value=0; then wedge_bound_ratio=0x10000001 -> cmp_value=1.
REQ-043 Scenario: 8 back-to-back beats with rect_idx 0..7, ready_in toggling 1,0,0,1 -> outputs 0..7 in order, stable while stalled, no loss.
REQ-044 Scenario: LAT=3 with 3 beats in flight, flush pulsed for 1 cycle -> valid_out stays 0 for 3 cycles; the next accepted beat emerges normally.
REQ-045 Scenario: rst asserted asynchronously mid-stream, off clock edge -> valid_out=0 and hit_count=0 immediately; ready_out=1 after release.
REQ-046 Scenario: 5 delivered beats with cmp 1,0,1,1,0 plus 2 flushed cmp=1 beats -> hit_count=3.
